// File: rtl/regfile_pkg.sv
// Shared register-file constants and types used by the write-back path.
package regfile_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       xdata_t;

endpackage : regfile_pkg

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Round-robin arbiter: the search starts at ptr and wraps; the pointer moves
// to one past the granted index whenever the grant is taken.
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [N-1:0] valid,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] grant_idx;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        logic found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (int'(ptr) + k) % N;
            if (!found && valid[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = PW'(idx);
                found      = 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments only.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (grant_idx == PW'(N - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule : rr_arbiter

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter and RAW scoreboard for the register file write port.
// Define REGFILE_SCOREBOARD_EN to build the busy scoreboard and conflict flag.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int XLEN    = regfile_pkg::XLEN
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*5-1:0]    req_addr,
    input  logic [NUM_REQ*XLEN-1:0] req_data,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic                    rf_write_enable,
    output reg_addr_t               rf_write_addr,
    output logic [XLEN-1:0]         rf_write_data,
    input  logic                    rsv_valid,
    input  reg_addr_t               rsv_addr,
    input  reg_addr_t               chk_addr1,
    input  reg_addr_t               chk_addr2,
    output logic                    chk_busy1,
    output logic                    chk_busy2,
    output logic                    rsv_conflict
);

    logic            transfer;
    reg_addr_t       sel_addr;
    logic [XLEN-1:0] sel_data;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .valid   (req_valid),
        .advance (transfer),
        .grant   (req_ready)
    );

    assign transfer = |(req_valid & req_ready);

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) begin
                sel_addr = req_addr[REG_ADDR_W*i +: REG_ADDR_W];
                sel_data = req_data[XLEN*i +: XLEN];
            end
        end
    end

    // A write to x0 completes its handshake but never reaches the file.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rf_write_enable <= 1'b0;
            rf_write_addr   <= '0;
            rf_write_data   <= '0;
        end else if (transfer) begin
            rf_write_enable <= (sel_addr != '0);
            rf_write_addr   <= sel_addr;
            rf_write_data   <= sel_data;
        end else begin
            rf_write_enable <= 1'b0;
        end
    end

`ifdef REGFILE_SCOREBOARD_EN
    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_next;
    logic                conflict_now;

    // Clear first, then set, so a same-cycle reserve of the retiring register wins.
    always_comb begin
        busy_next = busy;
        if (transfer) begin
            busy_next[sel_addr] = 1'b0;
        end
        if (rsv_valid && (rsv_addr != '0)) begin
            busy_next[rsv_addr] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    assign conflict_now = rsv_valid && busy[rsv_addr]
                          && !(transfer && (sel_addr == rsv_addr));

    // NOTE: the busy vector is a flop array, so it takes an async reset like any state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy         <= '0;
            rsv_conflict <= 1'b0;
        end else begin
            busy <= busy_next;
            if (conflict_now) begin
                rsv_conflict <= 1'b1;
            end
        end
    end

    assign chk_busy1 = busy[chk_addr1];
    assign chk_busy2 = busy[chk_addr2];
`else
    logic unused_rsv;
    assign unused_rsv   = ^{rsv_valid, rsv_addr, chk_addr1, chk_addr2};
    assign chk_busy1    = 1'b0;
    assign chk_busy2    = 1'b0;
    assign rsv_conflict = 1'b0;
`endif

endmodule : regfile_wb_arbiter

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter (NUM_REQ=3, XLEN=32);
// scoreboard checks follow REGFILE_SCOREBOARD_EN.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  req_valid;
    logic [14:0] req_addr;
    logic [95:0] req_data;
    logic [2:0]  req_ready;
    logic        rf_write_enable;
    logic [4:0]  rf_write_addr;
    logic [31:0] rf_write_data;
    logic        rsv_valid;
    logic [4:0]  rsv_addr;
    logic [4:0]  chk_addr1;
    logic [4:0]  chk_addr2;
    logic        chk_busy1;
    logic        chk_busy2;
    logic        rsv_conflict;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.NUM_REQ(3), .XLEN(32)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .req_valid       (req_valid),
        .req_addr        (req_addr),
        .req_data        (req_data),
        .req_ready       (req_ready),
        .rf_write_enable (rf_write_enable),
        .rf_write_addr   (rf_write_addr),
        .rf_write_data   (rf_write_data),
        .rsv_valid       (rsv_valid),
        .rsv_addr        (rsv_addr),
        .chk_addr1       (chk_addr1),
        .chk_addr2       (chk_addr2),
        .chk_busy1       (chk_busy1),
        .chk_busy2       (chk_busy2),
        .rsv_conflict    (rsv_conflict)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Step past the next rising edge; inputs are driven and outputs sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [4:0] a, input logic [31:0] d);
        req_valid[i]         = v;
        req_addr[5*i +: 5]   = a;
        req_data[32*i +: 32] = d;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        rsv_valid = 1'b0;
        rsv_addr  = '0;
        chk_addr1 = '0;
        chk_addr2 = '0;
        #12;
        @(negedge clk);
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        do_reset();
        check("rst_we",       rf_write_enable, 1'b0);
        check("rst_addr",     rf_write_addr,   5'd0);
        check("rst_data",     rf_write_data,   32'd0);
        check("rst_ready",    req_ready,       3'b000);
        check("rst_busy1",    chk_busy1,       1'b0);
        check("rst_conflict", rsv_conflict,    1'b0);

        // Single write
        set_req(0, 1'b1, 5'd5, 32'hDEADBEEF);
        #1 check("single_ready", req_ready, 3'b001);
        tick();
        set_req(0, 1'b0, 5'd0, 32'd0);
        check("single_we",   rf_write_enable, 1'b1);
        check("single_addr", rf_write_addr,   5'd5);
        check("single_data", rf_write_data,   32'hDEADBEEF);
        tick();
        check("single_we_off",    rf_write_enable, 1'b0);
        check("single_addr_hold", rf_write_addr,   5'd5);

        // Fairness from ptr = 0
        do_reset();
        for (int i = 0; i < 3; i++) set_req(i, 1'b1, 5'(i + 1), 32'h100 + 32'(i));
        for (int k = 0; k < 6; k++) begin
            #1 check($sformatf("fair_ready_%0d", k), req_ready, 3'b001 << (k % 3));
            tick();
            check($sformatf("fair_we_%0d", k),   rf_write_enable, 1'b1);
            check($sformatf("fair_addr_%0d", k), rf_write_addr,   5'((k % 3) + 1));
            check($sformatf("fair_data_%0d", k), rf_write_data,   32'h100 + 32'(k % 3));
        end
        req_valid = '0;

        // x0 write dropped but handshaken; ptr moves to 2
        set_req(1, 1'b1, 5'd0, 32'h1234);
        #1 check("x0_ready", req_ready, 3'b010);
        tick();
        set_req(1, 1'b0, 5'd0, 32'd0);
        check("x0_we",   rf_write_enable, 1'b0);
        check("x0_data", rf_write_data,   32'h1234);
        set_req(1, 1'b1, 5'd9, 32'h9);
        set_req(2, 1'b1, 5'd10, 32'hA);
        #1 check("x0_ptr_adv", req_ready, 3'b100);
        tick();
        check("x0_next_addr", rf_write_addr, 5'd10);
        req_valid = '0;
        tick();

        // Scoreboard (ptr = 0 here)
        rsv_valid = 1'b1;
        rsv_addr  = 5'd7;
        tick();
        rsv_valid = 1'b0;
        chk_addr1 = 5'd7;
        chk_addr2 = 5'd0;
        #1;
`ifdef REGFILE_SCOREBOARD_EN
        check("sb_busy_set",  chk_busy1, 1'b1);
        check("sb_busy_x0",   chk_busy2, 1'b0);
        set_req(2, 1'b1, 5'd7, 32'h77);
        #1 check("sb_busy_pre_grant", chk_busy1, 1'b1);
        tick();
        set_req(2, 1'b0, 5'd0, 32'd0);
        check("sb_busy_cleared", chk_busy1, 1'b0);
        // Reserve and retire r7 together: reserve wins
        rsv_valid = 1'b1;
        rsv_addr  = 5'd7;
        set_req(2, 1'b1, 5'd7, 32'h78);
        tick();
        check("sb_set_wins", chk_busy1, 1'b1);
        check("sb_no_conflict_idle", rsv_conflict, 1'b0);
        // Reserve busy r7 while it retires: no conflict
        tick();
        set_req(2, 1'b0, 5'd0, 32'd0);
        check("sb_set_wins2", chk_busy1, 1'b1);
        check("sb_no_conflict_clear", rsv_conflict, 1'b0);
        // Reserve busy r7 with no retire: conflict, sticky
        tick();
        rsv_valid = 1'b0;
        check("sb_conflict", rsv_conflict, 1'b1);
        tick();
        tick();
        check("sb_conflict_sticky", rsv_conflict, 1'b1);
`else
        check("nosb_busy1",    chk_busy1,    1'b0);
        check("nosb_busy2",    chk_busy2,    1'b0);
        check("nosb_conflict", rsv_conflict, 1'b0);
`endif

        // Reset mid-flight; ptr is 0 in both builds here
        set_req(1, 1'b1, 5'd12, 32'h55);
        #1 check("mid_ready", req_ready, 3'b010);
        tick();
        set_req(1, 1'b0, 5'd0, 32'd0);
        check("mid_we", rf_write_enable, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_we",       rf_write_enable, 1'b0);
        check("mid_rst_busy",     chk_busy1,       1'b0);
        check("mid_rst_conflict", rsv_conflict,    1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) set_req(i, 1'b1, 5'(i + 20), 32'(i));
        #1 check("mid_ptr_reset", req_ready, 3'b001);
        tick();
        check("mid_first_addr", rf_write_addr, 5'd20);
        req_valid = '0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_regfile_wb_arbiter
